// File: rtl/de0_nano_wb_pkg.sv
// Shared Wishbone B3 constants and arbiter state encoding for the DE0-Nano
// two-master CPU bus arbiter.
package de0_nano_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_G0    = 2'd1,
    ST_G1    = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/de0_nano_wb_watchdog.sv
// Bus watchdog: counts strobed cycles without a slave response and flags the
// cycle in which the transfer has waited TIMEOUT cycles.
module de0_nano_wb_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic strobed,
  input  logic resp,
  input  logic clear,
  output logic fire
);

  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] LIMIT = TO_W'(LIM);

  logic [TO_W-1:0] count_reg;
  logic [TO_W-1:0] count_next;
  logic            restart;

  assign restart = clear | resp | ~strobed;

  // Saturate so a disabled watchdog never wraps back into range.
  always_comb begin
    count_next = count_reg;
    if (restart) begin
      count_next = '0;
    end else if (count_reg != '1) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A response in the limit cycle wins over the abort.
  assign fire = (TIMEOUT != 0) && strobed && !resp && (count_reg == LIMIT);

endmodule

// File: rtl/de0_nano_wb_arbiter.sv
// Two-master (instruction / data) to one-slave Wishbone B3 arbiter with
// burst-aware round-robin grants and a hung-slave watchdog.
module de0_nano_wb_arbiter
  import de0_nano_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   wbm0_adr_i,
  input  logic [DW-1:0]   wbm0_dat_i,
  input  logic [DW/8-1:0] wbm0_sel_i,
  input  logic            wbm0_we_i,
  input  logic            wbm0_cyc_i,
  input  logic            wbm0_stb_i,
  input  logic [2:0]      wbm0_cti_i,
  input  logic [1:0]      wbm0_bte_i,
  output logic [DW-1:0]   wbm0_dat_o,
  output logic            wbm0_ack_o,
  output logic            wbm0_err_o,
  output logic            wbm0_rty_o,
  input  logic [AW-1:0]   wbm1_adr_i,
  input  logic [DW-1:0]   wbm1_dat_i,
  input  logic [DW/8-1:0] wbm1_sel_i,
  input  logic            wbm1_we_i,
  input  logic            wbm1_cyc_i,
  input  logic            wbm1_stb_i,
  input  logic [2:0]      wbm1_cti_i,
  input  logic [1:0]      wbm1_bte_i,
  output logic [DW-1:0]   wbm1_dat_o,
  output logic            wbm1_ack_o,
  output logic            wbm1_err_o,
  output logic            wbm1_rty_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic            wbs_we_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  arb_state_t state_reg, state_next;
  logic       last_reg, last_next;
  logic       abort_m_reg, abort_m_next;
  logic       fire;
  logic [1:0] live_grant;
  logic [1:0] abort_err;
  logic [1:0] m_stb, m_ack, m_err, m_rty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      last_reg    <= 1'b1;
      abort_m_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      abort_m_reg <= abort_m_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    abort_m_next = abort_m_reg;
    wbs_adr_o    = '0;
    wbs_dat_o    = '0;
    wbs_sel_o    = '0;
    wbs_we_o     = 1'b0;
    wbs_cyc_o    = 1'b0;
    wbs_stb_o    = 1'b0;
    wbs_cti_o    = CTI_CLASSIC;
    wbs_bte_o    = BTE_LINEAR;
    case (state_reg)
      ST_IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i) begin
          state_next = last_reg ? ST_G0 : ST_G1;
        end else if (wbm0_cyc_i) begin
          state_next = ST_G0;
        end else if (wbm1_cyc_i) begin
          state_next = ST_G1;
        end
      end
      ST_G0: begin
        wbs_adr_o = wbm0_adr_i;
        wbs_dat_o = wbm0_dat_i;
        wbs_sel_o = wbm0_sel_i;
        wbs_we_o  = wbm0_we_i;
        wbs_cyc_o = wbm0_cyc_i;
        wbs_stb_o = wbm0_stb_i;
        wbs_cti_o = wbm0_cti_i;
        wbs_bte_o = wbm0_bte_i;
        // Release takes priority over a simultaneous watchdog fire.
        if (!wbm0_cyc_i) begin
          last_next  = 1'b0;
          state_next = wbm1_cyc_i ? ST_G1 : ST_IDLE;
        end else if (fire) begin
          abort_m_next = 1'b0;
          state_next   = ST_ABORT;
        end
      end
      ST_G1: begin
        wbs_adr_o = wbm1_adr_i;
        wbs_dat_o = wbm1_dat_i;
        wbs_sel_o = wbm1_sel_i;
        wbs_we_o  = wbm1_we_i;
        wbs_cyc_o = wbm1_cyc_i;
        wbs_stb_o = wbm1_stb_i;
        wbs_cti_o = wbm1_cti_i;
        wbs_bte_o = wbm1_bte_i;
        if (!wbm1_cyc_i) begin
          last_next  = 1'b1;
          state_next = wbm0_cyc_i ? ST_G0 : ST_IDLE;
        end else if (fire) begin
          abort_m_next = 1'b1;
          state_next   = ST_ABORT;
        end
      end
      default: begin
        last_next = abort_m_reg;
        if (abort_m_reg) begin
          state_next = wbm0_cyc_i ? ST_G0 : ST_IDLE;
        end else begin
          state_next = wbm1_cyc_i ? ST_G1 : ST_IDLE;
        end
      end
    endcase
  end

  de0_nano_wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .strobed (wbs_stb_o),
    .resp    (wbs_ack_i | wbs_err_i | wbs_rty_i),
    .clear   (state_next != state_reg),
    .fire    (fire)
  );

  // Slave responses only reach a master that currently owns the bus; ABORT
  // owns nothing, so a late slave ack there is dropped.
  assign live_grant = (state_reg == ST_G0) ? 2'b01 :
                      (state_reg == ST_G1) ? 2'b10 : 2'b00;
  assign abort_err  = (state_reg != ST_ABORT) ? 2'b00 :
                      (abort_m_reg ? 2'b10 : 2'b01);
  assign grant_o    = live_grant | abort_err;
  assign timeout_o  = (state_reg == ST_ABORT);
  assign m_stb      = {wbm1_stb_i, wbm0_stb_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign m_ack[gi] = wbs_ack_i & live_grant[gi] & m_stb[gi];
      assign m_err[gi] = (wbs_err_i & live_grant[gi] & m_stb[gi]) | abort_err[gi];
      assign m_rty[gi] = wbs_rty_i & live_grant[gi] & m_stb[gi];
    end
  endgenerate

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = m_ack[0];
  assign wbm0_err_o = m_err[0];
  assign wbm0_rty_o = m_rty[0];
  assign wbm1_ack_o = m_ack[1];
  assign wbm1_err_o = m_err[1];
  assign wbm1_rty_o = m_rty[1];

endmodule
